nr_l2dl_rd_req: RTL and testbench

Read initiator for the L2 downlink buffer read port (re/raddr/tag request, fixed-latency rvld/rdata return with no backpressure). Takes burst commands (start address, beat count, command id) and issues one 128-bit read per cycle. It only issues a read when free space for that read's return data is guaranteed. Returned beats are byte/bit-reordered per configuration, buffered, and delivered on a valid/ready stream with a last marker. It instantiates twice, as the MAC and DTC read requesters in nr_l2_downlink.

---
 rtl/nr_l2dl_rd_req.sv | 269 ++++++++++++++++++++++++++
 tb/tb_nr_l2dl_rd_req.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_l2dl_rd_req.sv
// nr_l2dl_rd_req: L2 downlink buffer read initiator.
// Accepts burst commands and issues one fixed-latency read per cycle, but only
// when room for the returned beat is already reserved in the return FIFO.
// Returned words are byte/bit reordered, buffered, and streamed out with a
// last marker and the originating command id.
module nr_l2dl_rd_req #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 128,
    parameter int LEN_W      = 10,
    parameter int RD_LAT     = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk983m,
    input  logic              clkgen_rstn,
    input  logic              cfg_byte_inv_en,
    input  logic              cfg_bit_inv_en,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [4:0]        cmd_id,
    output logic              l2_re,
    output logic [ADDR_W-1:0] l2_raddr,
    output logic [11:0]       l2_tag,
    input  logic              l2_rvld,
    input  logic [DATA_W-1:0] l2_rdata,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [4:0]        out_id,
    output logic              busy,
    output logic              err_unexp
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NBYTES = DATA_W / 8;
    localparam int ENT_W  = DATA_W + 6;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Command / issue state
    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W:0]    remaining_r;
    logic [4:0]        id_r;
    logic [6:0]        beat_idx_r;
    logic              l2_last_r;

    // Credit accounting and return FIFO
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  fifo_cnt_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];

    // Tracking pipeline aligned with the fixed read latency
    logic              trk_vld_r  [RD_LAT];
    logic              trk_last_r [RD_LAT];
    logic [4:0]        trk_id_r   [RD_LAT];

    // Combinational control
    logic              accept_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              final_s;
    logic              idle_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic              unexp_s;
    logic [CNT_W-1:0]  outstanding_nxt_s;
    logic [CNT_W-1:0]  fifo_cnt_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [ENT_W-1:0]  push_ent_s;
    logic [ENT_W-1:0]  head_ent_s;

    // Byte-order and bit-order reversal of one returned word.
    // With both enables set the result is a full-width bit reversal.
    function automatic logic [DATA_W-1:0] reorder(
        input logic [DATA_W-1:0] din,
        input logic              byte_inv,
        input logic              bit_inv
    );
        logic [DATA_W-1:0] dout;
        logic [7:0]        b;
        dout = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_inv) begin
                b = din[(NBYTES-1-i)*8 +: 8];
            end else begin
                b = din[i*8 +: 8];
            end
            if (bit_inv) begin
                for (int j = 0; j < 8; j++) begin
                    dout[i*8+j] = b[7-j];
                end
            end else begin
                dout[i*8 +: 8] = b;
            end
        end
        return dout;
    endfunction

    // Handshake decode, credit check, counter and FIFO next-state values
    always_comb begin
        accept_s    = (state_r == IDLE) && cmd_vld && cmd_rdy;
        // outstanding counts a read from the edge it is issued, so the sum is
        // always the number of FIFO slots already promised away
        credit_ok_s = (({1'b0, outstanding_r} + {1'b0, fifo_cnt_r}) < DEPTH_C);
        issue_s     = (state_r == ISSUE) && credit_ok_s;
        final_s     = issue_s && (remaining_r == (LEN_W + 1)'(1));
        idle_nxt_s  = ((state_r == IDLE) && !accept_s) || final_s;
        push_s      = l2_rvld && (outstanding_r != '0);
        unexp_s     = l2_rvld && (outstanding_r == '0);
        pop_s       = out_vld && out_rdy;

        case ({issue_s, push_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase

        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        push_ent_s = {trk_last_r[RD_LAT-1] & trk_vld_r[RD_LAT-1],
                      trk_id_r[RD_LAT-1],
                      reorder(l2_rdata, cfg_byte_inv_en, cfg_bit_inv_en)};

        // A beat pushed into the slot that becomes the head bypasses the array
        if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_ent_s = push_ent_s;
        end else begin
            head_ent_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Command FSM: accept a burst, then issue one read per credited cycle
    always_ff @(posedge clk983m) begin
        if (!clkgen_rstn) begin
            state_r     <= IDLE;
            cmd_rdy     <= 1'b0;
            l2_re       <= 1'b0;
            l2_raddr    <= '0;
            l2_tag      <= 12'h000;
            l2_last_r   <= 1'b0;
            addr_r      <= '0;
            remaining_r <= '0;
            id_r        <= 5'd0;
            beat_idx_r  <= 7'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    l2_re <= 1'b0;
                    if (accept_s) begin
                        addr_r <= cmd_addr;
                        if (cmd_len == '0) begin
                            remaining_r <= {1'b1, {LEN_W{1'b0}}};
                        end else begin
                            remaining_r <= {1'b0, cmd_len};
                        end
                        id_r       <= cmd_id;
                        beat_idx_r <= 7'd0;
                        cmd_rdy    <= 1'b0;
                        state_r    <= ISSUE;
                    end else begin
                        cmd_rdy <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_s) begin
                        l2_re       <= 1'b1;
                        l2_raddr    <= addr_r;
                        l2_tag      <= {id_r, beat_idx_r};
                        l2_last_r   <= final_s;
                        addr_r      <= addr_r + ADDR_W'(1);
                        beat_idx_r  <= beat_idx_r + 7'd1;
                        remaining_r <= remaining_r - (LEN_W + 1)'(1);
                        if (final_s) begin
                            state_r <= IDLE;
                            cmd_rdy <= 1'b1;
                        end else begin
                            cmd_rdy <= 1'b0;
                        end
                    end else begin
                        l2_re   <= 1'b0;
                        cmd_rdy <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cmd_rdy <= 1'b0;
                    l2_re   <= 1'b0;
                end
            endcase
        end
    end

    // Tracking shift register: {valid, last, id} follows each read to its return
    always_ff @(posedge clk983m) begin
        if (!clkgen_rstn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                trk_vld_r[k]  <= 1'b0;
                trk_last_r[k] <= 1'b0;
                trk_id_r[k]   <= 5'd0;
            end
        end else begin
            trk_vld_r[0]  <= l2_re;
            trk_last_r[0] <= l2_last_r;
            trk_id_r[0]   <= l2_tag[11:7];
            for (int k = 1; k < RD_LAT; k++) begin
                trk_vld_r[k]  <= trk_vld_r[k-1];
                trk_last_r[k] <= trk_last_r[k-1];
                trk_id_r[k]   <= trk_id_r[k-1];
            end
        end
    end

    // Return FIFO storage write
    always_ff @(posedge clk983m) begin
        if (clkgen_rstn && push_s) begin
            mem_r[wr_ptr_r] <= push_ent_s;
        end
    end

    // Credit counters, FIFO pointers, registered output head, busy and error flag
    always_ff @(posedge clk983m) begin
        if (!clkgen_rstn) begin
            outstanding_r <= '0;
            fifo_cnt_r    <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            out_vld       <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            out_id        <= 5'd0;
            busy          <= 1'b0;
            err_unexp     <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            fifo_cnt_r    <= fifo_cnt_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            out_vld <= (fifo_cnt_nxt_s != '0);
            if (fifo_cnt_nxt_s != '0) begin
                {out_last, out_id, out_data} <= head_ent_s;
            end
            busy      <= !(idle_nxt_s && (outstanding_nxt_s == '0) && (fifo_cnt_nxt_s == '0));
            err_unexp <= err_unexp | unexp_s;
        end
    end

endmodule

// File: tb/tb_nr_l2dl_rd_req.sv
// Directed self-checking bench for nr_l2dl_rd_req with a fixed-latency L2 model.
module tb_nr_l2dl_rd_req;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 10;
    localparam int RD_LAT = 5;

    logic              clk983m = 1'b0;
    logic              clkgen_rstn = 1'b0;
    logic              cfg_byte_inv_en = 1'b0;
    logic              cfg_bit_inv_en = 1'b0;
    logic              cmd_vld = 1'b0;
    logic              cmd_rdy;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [4:0]        cmd_id = '0;
    logic              l2_re;
    logic [ADDR_W-1:0] l2_raddr;
    logic [11:0]       l2_tag;
    logic              l2_rvld;
    logic [DATA_W-1:0] l2_rdata;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [4:0]        out_id;
    logic              busy;
    logic              err_unexp;

    nr_l2dl_rd_req #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(16)
    ) dut (
        .clk983m(clk983m), .clkgen_rstn(clkgen_rstn),
        .cfg_byte_inv_en(cfg_byte_inv_en), .cfg_bit_inv_en(cfg_bit_inv_en),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .l2_re(l2_re), .l2_raddr(l2_raddr), .l2_tag(l2_tag), .l2_rvld(l2_rvld), .l2_rdata(l2_rdata),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last), .out_id(out_id),
        .busy(busy), .err_unexp(err_unexp)
    );

    always #5 clk983m = ~clk983m;

    function automatic logic [127:0] data_fn(input logic [13:0] a);
        return {8{2'b00, a}};
    endfunction

    // L2 model: returns data derived from the address RD_LAT cycles after l2_re
    logic [RD_LAT-1:0] pv = '0;
    logic [ADDR_W-1:0] pa [RD_LAT];
    logic              inj = 1'b0;
    logic              use_fixed = 1'b0;
    logic [127:0]      fixed_data = '0;

    always @(posedge clk983m) begin
        pv    <= {pv[RD_LAT-2:0], l2_re};
        pa[0] <= l2_raddr;
        for (int k = 1; k < RD_LAT; k++) pa[k] <= pa[k-1];
    end

    assign l2_rvld  = pv[RD_LAT-1] | inj;
    assign l2_rdata = inj ? 128'hDEAD_BEEF : (use_fixed ? fixed_data : data_fn(pa[RD_LAT-1]));

    // Monitor: log every read request and every accepted output beat
    int           cyc = 0;
    int           re_total = 0;
    int           pop_total = 0;
    logic [13:0]  re_addr_q[$];
    logic [11:0]  re_tag_q[$];
    int           re_cyc_q[$];
    logic [127:0] od_q[$];
    logic         ol_q[$];
    logic [4:0]   oi_q[$];
    int           oc_q[$];

    always @(posedge clk983m) begin
        cyc <= cyc + 1;
        if (l2_re) begin
            re_addr_q.push_back(l2_raddr);
            re_tag_q.push_back(l2_tag);
            re_cyc_q.push_back(cyc);
            re_total <= re_total + 1;
        end
        if (out_vld && out_rdy) begin
            od_q.push_back(out_data);
            ol_q.push_back(out_last);
            oi_q.push_back(out_id);
            oc_q.push_back(cyc);
            pop_total <= pop_total + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    int base_re = 0;
    int base_out = 0;
    int max_inflight = 0;
    int acc_cyc = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk983m);
        if (re_total - pop_total > max_inflight) max_inflight = re_total - pop_total;
    endtask

    task automatic mark();
        base_re  = re_addr_q.size();
        base_out = od_q.size();
    endtask

    task automatic send_cmd(input logic [13:0] a, input logic [9:0] l, input logic [4:0] id,
                            input int limit, input string tag);
        logic acc;
        acc = 1'b0;
        tick();
        cmd_vld = 1'b1; cmd_addr = a; cmd_len = l; cmd_id = id;
        for (int k = 0; k < limit && !acc; k++) begin
            if (cmd_rdy) begin
                acc = 1'b1;
                acc_cyc = cyc;
            end else begin
                tick();
            end
        end
        tick();
        cmd_vld = 1'b0;
        chk(tag, acc, 1'b1);
    endtask

    task automatic wait_done(input int n_re, input int n_out, input int limit, input string tag);
        logic done;
        done = 1'b0;
        for (int k = 0; k < limit && !done; k++) begin
            tick();
            done = (re_addr_q.size() >= base_re + n_re) && (od_q.size() >= base_out + n_out) && !busy;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_cmd_rdy"}, cmd_rdy, 1'b0);
        chk({p, "_l2_re"}, l2_re, 1'b0);
        chk({p, "_l2_raddr"}, l2_raddr, 14'h0);
        chk({p, "_l2_tag"}, l2_tag, 12'h0);
        chk({p, "_out_vld"}, out_vld, 1'b0);
        chk({p, "_out_last"}, out_last, 1'b0);
        chk({p, "_out_id"}, out_id, 5'd0);
        chk({p, "_out_data"}, out_data, 128'h0);
        chk({p, "_busy"}, busy, 1'b0);
        chk({p, "_err_unexp"}, err_unexp, 1'b0);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk_reset("rst");
        clkgen_rstn = 1'b1;
        tick();
        chk("rst_cmd_rdy_after", cmd_rdy, 1'b1);

        // Basic burst: addr 0x10, len 4, id 3
        out_rdy = 1'b1;
        mark();
        send_cmd(14'h0010, 10'd4, 5'd3, 50, "t1_accept");
        wait_done(4, 4, 200, "t1_done");
        chk("t1_re_count", re_addr_q.size() - base_re, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_raddr", re_addr_q[base_re+i], 14'(16 + i));
            chk("t1_tag", re_tag_q[base_re+i], 12'(384 + i));
            chk("t1_re_cycle", re_cyc_q[base_re+i], re_cyc_q[base_re] + i);
            chk("t1_data", od_q[base_out+i], data_fn(14'(16 + i)));
            chk("t1_last", ol_q[base_out+i], (i == 3));
            chk("t1_id", oi_q[base_out+i], 5'd3);
            chk("t1_out_cycle", oc_q[base_out+i], oc_q[base_out] + i);
        end
        chk("t1_first_out_latency", oc_q[base_out], re_cyc_q[base_re] + RD_LAT + 1);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_out_vld_end", out_vld, 1'b0);

        // Address wrap
        mark();
        send_cmd(14'h3FFE, 10'd4, 5'd1, 50, "t2_accept");
        wait_done(4, 4, 200, "t2_done");
        chk("t2_raddr0", re_addr_q[base_re], 14'h3FFE);
        chk("t2_raddr1", re_addr_q[base_re+1], 14'h3FFF);
        chk("t2_raddr2", re_addr_q[base_re+2], 14'h0000);
        chk("t2_raddr3", re_addr_q[base_re+3], 14'h0001);
        chk("t2_data2", od_q[base_out+2], data_fn(14'h0000));

        // Backpressure: only FIFO_DEPTH reads issue while the output is stalled
        out_rdy = 1'b0;
        mark();
        max_inflight = 0;
        send_cmd(14'h0100, 10'd40, 5'd5, 50, "t3_accept");
        repeat (60) tick();
        chk("t3_re_count_stalled", re_addr_q.size() - base_re, 16);
        chk("t3_out_vld_stalled", out_vld, 1'b1);
        chk("t3_head_data", out_data, data_fn(14'h0100));
        chk("t3_head_id", out_id, 5'd5);
        repeat (10) tick();
        chk("t3_re_count_still", re_addr_q.size() - base_re, 16);
        chk("t3_head_stable", out_data, data_fn(14'h0100));
        out_rdy = 1'b1;
        wait_done(40, 40, 500, "t3_done");
        chk("t3_out_count", od_q.size() - base_out, 40);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (od_q[base_out+i] !== data_fn(14'(256 + i))) bad++;
            if (ol_q[base_out+i] !== (i == 39)) bad++;
            if (oi_q[base_out+i] !== 5'd5) bad++;
        end
        chk("t3_beats_bad", bad, 0);
        chk("t3_max_inflight", max_inflight, 16);

        // Reordering
        use_fixed = 1'b1;
        fixed_data = 128'h000102030405060708090A0B0C0D0E0F;
        cfg_byte_inv_en = 1'b1;
        mark();
        send_cmd(14'h0020, 10'd1, 5'd4, 50, "t4a_accept");
        wait_done(1, 1, 100, "t4a_done");
        chk("t4a_byte_inv", od_q[base_out], 128'h0F0E0D0C0B0A09080706050403020100);
        cfg_byte_inv_en = 1'b0;
        cfg_bit_inv_en = 1'b1;
        mark();
        send_cmd(14'h0021, 10'd1, 5'd4, 50, "t4b_accept");
        wait_done(1, 1, 100, "t4b_done");
        chk("t4b_bit_inv", od_q[base_out], 128'h008040C020A060E0109050D030B070F0);
        cfg_byte_inv_en = 1'b1;
        fixed_data = 128'h1;
        mark();
        send_cmd(14'h0022, 10'd1, 5'd4, 50, "t4c_accept");
        wait_done(1, 1, 100, "t4c_done");
        chk("t4c_both", od_q[base_out], 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        cfg_byte_inv_en = 1'b0;
        cfg_bit_inv_en = 1'b0;
        use_fixed = 1'b0;

        // Maximum burst (len 0 = 1024) followed by a back-to-back single beat
        mark();
        send_cmd(14'h0000, 10'd0, 5'd2, 50, "t5a_accept");
        send_cmd(14'h0050, 10'd1, 5'd7, 2000, "t5b_accept");
        wait_done(1025, 1025, 300, "t5_done");
        chk("t5_re_count", re_addr_q.size() - base_re, 1025);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (re_addr_q[base_re+i] !== 14'(i)) bad++;
            if (re_tag_q[base_re+i] !== 12'((2 << 7) | (i & 127))) bad++;
            if (od_q[base_out+i] !== data_fn(14'(i))) bad++;
            if (ol_q[base_out+i] !== (i == 1023)) bad++;
            if (oi_q[base_out+i] !== 5'd2) bad++;
        end
        chk("t5_burst_bad", bad, 0);
        chk("t5_tag_wrap", re_tag_q[base_re+128], 12'h100);
        chk("t5_accept_cycle", acc_cyc, re_cyc_q[base_re+1023]);
        chk("t5_bubble", re_cyc_q[base_re+1024], re_cyc_q[base_re+1023] + 2);
        chk("t5b_raddr", re_addr_q[base_re+1024], 14'h0050);
        chk("t5b_tag", re_tag_q[base_re+1024], 12'h380);
        chk("t5b_last", ol_q[base_out+1024], 1'b1);
        chk("t5b_id", oi_q[base_out+1024], 5'd7);
        chk("t5b_data", od_q[base_out+1024], data_fn(14'h0050));

        // Unexpected return with nothing outstanding
        mark();
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("t6_err_set", err_unexp, 1'b1);
        repeat (5) tick();
        chk("t6_err_sticky", err_unexp, 1'b1);
        chk("t6_no_out_vld", out_vld, 1'b0);
        chk("t6_no_beats", od_q.size() - base_out, 0);

        // Reset in the middle of a stalled burst
        out_rdy = 1'b0;
        send_cmd(14'h0200, 10'd20, 5'd9, 50, "t7_accept");
        repeat (8) tick();
        chk("t7_busy_before", busy, 1'b1);
        clkgen_rstn = 1'b0;
        tick();
        chk_reset("t7_midrst");
        clkgen_rstn = 1'b1;
        repeat (8) tick();
        chk("t7_err_after", err_unexp, 1'b1);
        chk("t7_out_vld_after", out_vld, 1'b0);
        chk("t7_busy_after", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
